control: RTL and testbench
==========================

# control

Registered instruction-decode control unit for the RV32I integer datapath. Takes the `funct7`, `funct3` and `opcode` fields of the current instruction. Produces a 4-bit ALU operation select and the register-file write enable. Sits between instruction fetch/decode and the ALU/register file; outputs are registered on the single system clock.

## Interface
- No parameters.
- `clk`  input  1  system clock, rising-edge active.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `funct7`  input  7  instruction bits [31:25].
- `funct3`  input  3  instruction bits [14:12].
- `opcode`  input  7  instruction bits [6:0].
- `alu_control`  output  4  ALU operation select (registered).
- `regwrite_control`  output  1  register-file write enable (registered).

## Operation
- ALU encodings:
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0100
  - SLT=0101, XOR=0110, SRL=0111, SRA=1000, SLTU=1001
  - NOP=1111
- R-type (`opcode`=0110011), `funct7`=0000000:
  - `funct3` 000 ADD, 001 SLL, 010 SLT, 011 SLTU
  - 100 XOR, 101 SRL, 110 OR, 111 AND
  - `regwrite_control`=1.
- R-type, `funct7`=0100000:
  - `funct3` 000 SUB, 101 SRA; `regwrite_control`=1.
  - Any other `funct3` is illegal.
- R-type with any other `funct7` is illegal.
- I-type ALU (`opcode`=0010011), `regwrite_control`=1:
  - `funct3` 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND
  - 001 SLL, only with `funct7`=0000000
  - 101: SRL when `funct7`=0000000, SRA when `funct7`=0100000
  - `funct7` is ignored except for 001 and 101.
  - 001 or 101 with any other `funct7` is illegal.
- Illegal combinations and all other opcodes: `alu_control`=1111 (NOP), `regwrite_control`=0.
- Decode is purely a function of the three input fields; no internal state besides the output registers.

## Timing
- Decode logic is combinational; both outputs are captured on the rising `clk` edge.
- Latency: one cycle from an input change to the updated outputs.
- Both outputs update on the same edge.
- Inputs must be stable around the rising edge; no handshake.
- `rst_n` low clears immediately (no clock needed), regardless of inputs:
  - `alu_control`=0000
  - `regwrite_control`=0
- Reset held: outputs remain 0000/0.
- First rising edge after `rst_n` deasserts loads the decode of the current inputs.
- Reset asserted mid-stream: outputs clear at once; the pending decode is discarded.
- Back-to-back instructions on consecutive cycles: each output value corresponds to the inputs sampled at the preceding edge.

## Test plan
- ADD: `funct7`=0000000, `funct3`=000, `opcode`=0110011, one clock -> `alu_control`=0010, `regwrite_control`=1.
- SUB/OR/AND, same opcode, one clock each:
  - `funct7`=0100000, `funct3`=000 -> 0100/1
  - `funct7`=0000000, `funct3`=110 -> 0001/1
  - `funct3`=111 -> 0000/1
- SLL and stuck-at on `funct3[0]`:
  - `funct3`=001, R-type -> 0011/1.
  - `funct3[0]` forced 0 -> 0010/1; a checker expecting 0011 must flag a mismatch.
  - `funct3[0]` forced 1 -> 0011/1.
- I-type and shifts, `opcode`=0010011:
  - `funct3`=000, `funct7`=0100000 -> 0010/1 (no SUBI)
  - `funct3`=101, `funct7`=0100000 -> 1000/1
  - `funct3`=101, `funct7`=0000000 -> 0111/1
- Illegal/unsupported, one clock each -> 1111/0:
  - `opcode`=0000011
  - R-type `funct7`=0000001
  - R-type `funct7`=0100000 with `funct3`=110
- Reset:
  - Load ADD, then drive `rst_n` low between edges -> outputs 0000/0 immediately.
  - Release `rst_n` -> decode reappears on the next rising edge.

Source files
------------

// File: rtl/control.sv
// control: registered RV32I decode of funct7/funct3/opcode into an ALU
// operation select and a register-file write enable.
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic [3:0] alu_control,
  output logic       regwrite_control
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_NOP  = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  alu_op_e    base_op;
  alu_op_e    alu_control_d;
  alu_op_e    alu_control_q;
  logic       regwrite_control_d;
  logic       regwrite_control_q;

  // Operation implied by funct3 alone, shared by the R-type and I-type paths
  always_comb begin
    base_op = ALU_ADD;
    unique case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // Full decode; anything not explicitly legal falls through to NOP with no write
  always_comb begin
    alu_control_d      = ALU_NOP;
    regwrite_control_d = 1'b0;
    if (opcode == OP_RTYPE) begin
      if (funct7 == F7_BASE) begin
        alu_control_d      = base_op;
        regwrite_control_d = 1'b1;
      end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
        alu_control_d      = ALU_SUB;
        regwrite_control_d = 1'b1;
      end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
        alu_control_d      = ALU_SRA;
        regwrite_control_d = 1'b1;
      end
    end else if (opcode == OP_ITYPE) begin
      // Only the shift encodings look at funct7; the rest carry immediate bits there
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        if (funct7 == F7_BASE) begin
          alu_control_d      = base_op;
          regwrite_control_d = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_control_d      = ALU_SRA;
          regwrite_control_d = 1'b1;
        end
      end else begin
        alu_control_d      = base_op;
        regwrite_control_d = 1'b1;
      end
    end
  end

  // Output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control_q      <= ALU_AND;
      regwrite_control_q <= 1'b0;
    end else begin
      alu_control_q      <= alu_control_d;
      regwrite_control_q <= regwrite_control_d;
    end
  end

  assign alu_control      = alu_control_q;
  assign regwrite_control = regwrite_control_q;

endmodule

// File: tb/tb_control.sv
// tb_control: directed literal checks plus randomized stimulus compared every
// cycle against a table-driven reference model of the decode rules.
`timescale 1ns/1ps
module tb_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] opcode = '0;
  logic [3:0] alu_control;
  logic       regwrite_control;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic        cmp_en = 1'b0;

  logic [3:0]  exp_alu = '0;
  logic        exp_rw  = 1'b0;

  control dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .funct7           (funct7),
    .funct3           (funct3),
    .opcode           (opcode),
    .alu_control      (alu_control),
    .regwrite_control (regwrite_control)
  );

  always #5 clk = ~clk;

  // Reference: {regwrite, alu} from the instruction-field rules
  function automatic logic [4:0] ref_decode(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] op);
    logic [3:0] tab [8];
    logic       shift;
    tab[0] = 4'b0010; tab[1] = 4'b0011; tab[2] = 4'b0101; tab[3] = 4'b1001;
    tab[4] = 4'b0110; tab[5] = 4'b0111; tab[6] = 4'b0001; tab[7] = 4'b0000;
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (op == 7'h33) begin
      if (f7 == 7'h00)                 return {1'b1, tab[f3]};
      if (f7 == 7'h20 && f3 == 3'd0)   return {1'b1, 4'b0100};
      if (f7 == 7'h20 && f3 == 3'd5)   return {1'b1, 4'b1000};
      return {1'b0, 4'b1111};
    end
    if (op == 7'h13) begin
      if (!shift)                      return {1'b1, tab[f3]};
      if (f7 == 7'h00)                 return {1'b1, tab[f3]};
      if (f7 == 7'h20 && f3 == 3'd5)   return {1'b1, 4'b1000};
      return {1'b0, 4'b1111};
    end
    return {1'b0, 4'b1111};
  endfunction

  // Model output register: captures the reference at each edge, clears on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_alu <= '0;
      exp_rw  <= 1'b0;
    end else begin
      {exp_rw, exp_alu} <= ref_decode(funct7, funct3, opcode);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (alu_control === exp_alu && regwrite_control === exp_rw) passes++;
      else $display("FAIL model t=%0t f7=%h f3=%h op=%h got %b/%b want %b/%b", $time,
                    funct7, funct3, opcode, alu_control, regwrite_control, exp_alu, exp_rw);
    end
  end

  task automatic check_lit(input string name, input logic [3:0] a, input logic r);
    checks++;
    if (alu_control === a && regwrite_control === r) passes++;
    else $display("FAIL %s got %b/%b want %b/%b", name, alu_control, regwrite_control, a, r);
  endtask

  // Drive one instruction after an edge, then check its decode after the next edge
  task automatic instr(input string name, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [6:0] op, input logic [3:0] a, input logic r);
    @(posedge clk); #2;
    funct7 = f7; funct3 = f3; opcode = op;
    @(posedge clk); #1;
    check_lit(name, a, r);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_lit("reset_async", 4'b0000, 1'b0);
    funct7 = 7'h00; funct3 = 3'd0; opcode = 7'h33;
    @(posedge clk); #1 check_lit("reset_held", 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 check_lit("first_edge", 4'b0010, 1'b1);
    cmp_en = 1'b1;

    instr("add",      7'h00, 3'd0, 7'h33, 4'b0010, 1'b1);
    instr("sub",      7'h20, 3'd0, 7'h33, 4'b0100, 1'b1);
    instr("or",       7'h00, 3'd6, 7'h33, 4'b0001, 1'b1);
    instr("and",      7'h00, 3'd7, 7'h33, 4'b0000, 1'b1);
    instr("sll",      7'h00, 3'd1, 7'h33, 4'b0011, 1'b1);
    instr("f3b0_lo",  7'h00, 3'd0, 7'h33, 4'b0010, 1'b1);
    instr("f3b0_hi",  7'h00, 3'd1, 7'h33, 4'b0011, 1'b1);
    instr("sltu",     7'h00, 3'd3, 7'h33, 4'b1001, 1'b1);
    instr("sra",      7'h20, 3'd5, 7'h33, 4'b1000, 1'b1);
    instr("addi_f7",  7'h20, 3'd0, 7'h13, 4'b0010, 1'b1);
    instr("srai",     7'h20, 3'd5, 7'h13, 4'b1000, 1'b1);
    instr("srli",     7'h00, 3'd5, 7'h13, 4'b0111, 1'b1);
    instr("slti_f7",  7'h55, 3'd2, 7'h13, 4'b0101, 1'b1);
    instr("slli_bad", 7'h20, 3'd1, 7'h13, 4'b1111, 1'b0);
    instr("load",     7'h00, 3'd0, 7'h03, 4'b1111, 1'b0);
    instr("r_f7_01",  7'h01, 3'd0, 7'h33, 4'b1111, 1'b0);
    instr("r_alt_or", 7'h20, 3'd6, 7'h33, 4'b1111, 1'b0);

    // Mid-stream reset between edges, then release
    instr("add_pre",  7'h00, 3'd0, 7'h33, 4'b0010, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_lit("reset_mid", 4'b0000, 1'b0);
    @(posedge clk); #1 check_lit("reset_mid_held", 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    #1 check_lit("release_wait", 4'b0000, 1'b0);
    @(posedge clk); #1 check_lit("release_edge", 4'b0010, 1'b1);

    // Randomized back-to-back instructions with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      case ($urandom_range(0, 3))
        0:       opcode = 7'h33;
        1:       opcode = 7'h13;
        2:       opcode = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
        default: opcode = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       funct7 = 7'h00;
        1:       funct7 = 7'h20;
        default: funct7 = 7'($urandom);
      endcase
      funct3 = 3'($urandom);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
